// File: rtl/biquad_pkg.sv
// Shared types and constants for the biquad coefficient loaders.
// Holds the coefficient type, loader FSM states and the count helper.
package biquad_pkg;

  localparam int CBITS = 18;

  typedef logic signed [CBITS-1:0] coeff_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE,
    DONE
  } ld_state_e;

  function automatic int ncoeff(input int nsamp);
    return 2 * (nsamp - 2);
  endfunction

endpackage

// File: rtl/biquad_coeff_stage.sv
// Coefficient staging register file: one write port, one async read port.
// Ports: clk, rst_n, we/waddr/wdat (write), raddr/rdat (read); out of range ignored/0.
module biquad_coeff_stage
  import biquad_pkg::*;
#(
  parameter int N  = 12,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  coeff_t        wdat,
  input  logic [AW-1:0] raddr,
  output coeff_t        rdat
);

  coeff_t mem [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (int'(waddr) < N)) begin
      mem[waddr] <= wdat;
    end
  end

  assign rdat = (int'(raddr) < N) ? mem[raddr] : '0;

endmodule

// File: rtl/biquad8_coeff_loader.sv
// Stages IIR coefficients and shifts them down the DSP B-cascade on commit.
// Ports: cfg write port, commit/busy/done, coeff_dat/wr/update to the IIR;
// optional rd_addr_i/rd_dat_o readback under BIQUAD_COEFF_READBACK_EN.
module biquad8_coeff_loader
  import biquad_pkg::*;
#(
  parameter  int NSAMP  = 8,
  localparam int NCOEFF = ncoeff(NSAMP),
  localparam int ABITS  = $clog2(NCOEFF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [ABITS-1:0] cfg_addr_i,
  input  logic [CBITS-1:0] cfg_dat_i,
  input  logic             commit_i,
  output logic             busy_o,
  output logic             load_done_o,
`ifdef BIQUAD_COEFF_READBACK_EN
  input  logic [ABITS-1:0] rd_addr_i,
  output logic [CBITS-1:0] rd_dat_o,
`endif
  output logic [CBITS-1:0] coeff_dat_o,
  output logic             coeff_wr_o,
  output logic             coeff_update_o
);

  ld_state_e        state;
  ld_state_e        state_nxt;
  logic [ABITS-1:0] cnt;
  logic [ABITS-1:0] ridx;
  logic             pend;
  logic             wr_en;
  coeff_t           rdat;
  logic [CBITS-1:0] dat_q;
  logic             done_q;

  assign wr_en = cfg_valid_i && (state == IDLE);
  // Highest address first.
  assign ridx  = ABITS'(NCOEFF - 1) - cnt;

  biquad_coeff_stage #(
    .N  (NCOEFF),
    .AW (ABITS)
  ) u_stage (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (cfg_addr_i),
    .wdat  (cfg_dat_i),
    .raddr (ridx),
    .rdat  (rdat)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (commit_i || pend) state_nxt = SHIFT;
      SHIFT:  if (cnt == ABITS'(NCOEFF - 1)) state_nxt = UPDATE;
      UPDATE: state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      pend   <= 1'b0;
      dat_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= (state == SHIFT) ? cnt + 1'b1 : '0;
      // Data trails coeff_wr by one cycle to match the IIR's CEB1 delay.
      dat_q  <= (state == SHIFT) ? rdat : '0;
      done_q <= (state == DONE);
      // IDLE consumes the request; elsewhere commits collapse into one.
      pend   <= (state != IDLE) ? (pend | commit_i) : 1'b0;
    end
  end

  assign cfg_ready_o    = (state == IDLE);
  assign busy_o         = (state != IDLE);
  assign coeff_wr_o     = (state == SHIFT);
  assign coeff_update_o = (state == DONE);
  assign coeff_dat_o    = dat_q;
  assign load_done_o    = done_q;

`ifdef BIQUAD_COEFF_READBACK_EN
  // Shadow captures the shifted values; active flips in UPDATE only.
  coeff_t           shadow [NCOEFF];
  coeff_t           active [NCOEFF];
  logic [CBITS-1:0] rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCOEFF; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      if (state == SHIFT) shadow[ridx] <= rdat;
      if (state == UPDATE) begin
        for (int i = 0; i < NCOEFF; i++) begin
          active[i] <= shadow[i];
        end
      end
      rd_q <= (int'(rd_addr_i) < NCOEFF) ? active[rd_addr_i] : '0;
    end
  end

  assign rd_dat_o = rd_q;
`endif

endmodule
